// File: rtl/async_fifo_wr_feeder_if.sv
// Stream-side and FIFO-side signals of the write feeder.
// The master modport is the feeder itself. The slave modport is whatever
// sits around it: the upstream source and the FIFO write port.
interface async_fifo_wr_feeder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_full;

    modport master (
        input  s_valid,
        input  s_data,
        input  fifo_full,
        output s_ready,
        output fifo_wr_en,
        output fifo_data
    );

    modport slave (
        output s_valid,
        output s_data,
        output fifo_full,
        input  s_ready,
        input  fifo_wr_en,
        input  fifo_data
    );
endinterface

// File: rtl/async_fifo_wr_feeder.sv
// Write-side producer for the dual-clock gray-pointer FIFO (wr_clk domain).
// The FIFO registers wr_en internally, samples data one cycle later, and
// silently drops the write if full is high in that cycle. en_d1_q mirrors
// that internal enable register, so the feeder knows exactly which head
// word committed. A word that was dropped stays at the head and is retried.
// A two-entry queue keeps upstream flowing at one word per cycle.
module async_fifo_wr_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst_n,
    async_fifo_wr_feeder_if.master bus,
    output logic [CNT_WIDTH-1:0] wr_count_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic                 busy_o
);

    logic [DATA_WIDTH-1:0] q_mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  en_d1_q;
    logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;
    logic                  s_ready;
    logic                  push;
    logic                  commit;
    logic                  blocked;

    // Accept/commit/stall decisions plus next-state of the queue and statistics.
    always_comb begin
        s_ready       = rst_n && (cnt_q != 2'd2);
        push          = bus.s_valid && s_ready;
        commit        = en_d1_q && !bus.fifo_full && (cnt_q != 2'd0);
        blocked       = en_d1_q && bus.fifo_full;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (commit) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, commit})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        wr_count_d    = wr_count_q + {{(CNT_WIDTH-1){1'b0}}, commit};
        stall_count_d = stall_count_q + {{(CNT_WIDTH-1){1'b0}}, blocked};
    end

    // Enable is raised only when a word will be at the head next cycle, which
    // is the cycle in which the FIFO samples fifo_data.
    assign bus.s_ready    = s_ready;
    assign bus.fifo_wr_en = rst_n && (cnt_d != 2'd0);
    assign bus.fifo_data  = rst_n ? q_mem_q[rd_ptr_q] : '0;
    assign busy_o         = (cnt_q != 2'd0);
    assign wr_count_o     = wr_count_q;
    assign stall_count_o  = stall_count_q;

    // Queue pointers, occupancy, the shadow of the FIFO enable register, and the statistics.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
            en_d1_q       <= 1'b0;
            wr_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            en_d1_q       <= bus.fifo_wr_en;
            wr_count_q    <= wr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Queue storage; an accepted word is written at the tail.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            q_mem_q[0] <= '0;
            q_mem_q[1] <= '0;
        end else if (push) begin
            q_mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

endmodule

// File: doc/async_fifo_wr_feeder.md
Name: async_fifo_wr_feeder

Overview:
- Write-side producer for the team's dual-clock gray-pointer FIFO, living in the wr_clk domain.
- Converts an upstream valid/ready stream into the FIFO's write protocol. That protocol registers the write enable one cycle internally, samples data one cycle after enable, and silently drops the write if full is high in that cycle.
- The block tracks which words actually committed and retries dropped ones, so no word is ever lost or duplicated. It also provides commit and stall statistics.

Parameters:
- DATA_WIDTH, 8, width of stream and FIFO data.
- CNT_WIDTH, 16, width of statistics counters (wrap modulo 2^CNT_WIDTH).

Ports:
- wr_clk  in  1  write-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  upstream word valid.
- s_data  in  DATA_WIDTH  upstream word.
- s_ready  out  1  feeder can accept a word this cycle.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_data  out  DATA_WIDTH  to FIFO data_in.
- fifo_full  in  1  from FIFO full.
- wr_count  out  CNT_WIDTH  words committed into FIFO.
- stall_count  out  CNT_WIDTH  cycles a pending commit was blocked by full.
- busy  out  1  buffer holds an uncommitted word.

Behaviour:
- State:
  - 2-entry in-order queue Q with count register cnt (0..2).
  - Shadow register en_d1, which mirrors the FIFO's internal registered enable: en_d1 <= fifo_wr_en.
- Reset (async, rst_n low):
  - cnt=0, Q pointers=0, en_d1=0, wr_count=0, stall_count=0.
  - Outputs during reset: s_ready=0, fifo_wr_en=0, busy=0, fifo_data=0.
  - Q contents are discarded.
  - Reset mid-operation loses uncommitted words; no partial write is issued after reset.
- s_ready = (cnt < 2) when not in reset. It is driven from the register only, with no combinational path from s_valid.
- push = s_valid && s_ready. The word is appended to the Q tail at the clock edge.
- fifo_data = Q head (registered storage, muxed by head pointer). It holds stable while the head is uncommitted.
- commit = en_d1 && !fifo_full && cnt != 0. At that edge the FIFO writes fifo_data, and the feeder pops the head.
- blocked = en_d1 && fifo_full. The head is retained and stall_count increments.
- Invariant: en_d1=1 implies cnt!=0. A bench assertion must check this, since a violation would make the FIFO write stale data.
- fifo_wr_en = (cnt - commit + push) != 0, i.e. Q will be non-empty next cycle.
  - This is combinational from cnt, s_valid and fifo_full (intentional: the FIFO's enable register supplies the timing stage).
  - Consequence: enable is asserted in cycle N only if a word will be at the head in cycle N+1, when the FIFO samples data.
- Latency: a word pushed in cycle N is presented as the head in N+1, with fifo_wr_en high in N.
  - It commits at the end of N+1 if not full and the word is head (queue empty before the push).
  - Push-to-FIFO latency is therefore 2 cycles.
- Throughput: with continuous s_valid and no full, enable stays high and one word commits per cycle; s_ready stays 1 because cnt oscillates at most to 1.
- Full handling: while fifo_full=1, the head retries every cycle with enable held high.
  - Q fills to 2, then s_ready=0.
  - The first cycle full drops, the head commits; the order is preserved.
- Simultaneous push and commit at cnt=2 cannot occur (s_ready=0). At cnt=1, cnt stays 1.
- wr_count += commit; stall_count += blocked. Both wrap.
- busy = (cnt != 0).

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, s_valid=0 for 10 cycles -> fifo_wr_en=0, s_ready=1, wr_count=0, no FIFO write.
- Single word: push 0xA5 in cycle 5 -> fifo_wr_en=1 in cycle 5, fifo_data=0xA5 in cycle 6, commit at end of 6, wr_count=1, busy=0 in cycle 7, no second write.
- Streaming: push 0x00..0xFF back-to-back into a 256-deep FIFO with rd side idle -> 256 commits, wr_count=256, stall_count=0. The next push sees full; feeder holds 0x00 again; reader drains; sequence 0x00..0xFF then 0x00 arrives exactly once each.
- Full backpressure: FIFO full, push 0x11,0x22,0x33 -> 0x11,0x22 queued, s_ready=0, 0x33 held upstream; stall_count increments each cycle. After one read frees space, 0x11 commits first, then 0x22, 0x33, with no duplicates.
- Reset mid-stream: assert rst_n with cnt=2 during full -> cnt=0, fifo_wr_en=0 immediately, counters=0. After release, the next pushed word 0x5A is the first word read from the FIFO.
- Invariant and stale-data check: randomized s_valid and rd_en across ratios of 1:3 and 3:1 clock frequency, 10k words -> read sequence equals pushed sequence, en_d1&&cnt==0 never seen, and wr_count equals the number of words read plus the FIFO occupancy.
